// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte buffer and drain scheduler placed directly in front of uart_tx.
// Producers push bytes over a valid/ready handshake into a DEPTH-entry FIFO.
// A small drain FSM hands the bytes to uart_tx one at a time, and only when the
// transmitter reports idle, so producers can burst without knowing UART timing.
//
// DEPTH must be a power of two and at least 2, so the read and write pointers
// can wrap naturally.  Full and empty are taken from the occupancy counter and
// not from a pointer compare.

module uart_tx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_BITS-1:0]     in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_BITS-1:0]     uart_tx_data,
  output logic                     uart_tx_en,
  input  logic                     uart_tx_busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int ADDR_BITS = $clog2(DEPTH);
  localparam logic [ADDR_BITS:0] DEPTH_COUNT = (ADDR_BITS + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic                 push;
  logic                 pop;

  // Status flags depend only on the registered count.  Because of this, a pop
  // in the same cycle cannot make room for a push while the FIFO is full.
  assign empty    = (count == '0);
  assign full     = (count == DEPTH_COUNT);
  assign in_ready = !full;

  // A push is the handshake itself.  A pop is the edge where the drain FSM
  // leaves IDLE with a byte in hand.
  assign push = in_valid && in_ready;
  assign pop  = (state == IDLE) && !empty && !uart_tx_busy;

  // The storage array is deliberately left out of reset.  Any stale entries
  // are unreachable because the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Write pointer advances on each accepted byte and wraps at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + ADDR_BITS'(1);
    end
  end

  // Read pointer advances on each byte handed to the transmitter and wraps at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + ADDR_BITS'(1);
    end
  end

  // Occupancy counter.  A simultaneous push and pop cancels out.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + (ADDR_BITS + 1)'(1);
        2'b01:   count <= count - (ADDR_BITS + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Drain FSM.  It issues one registered strobe per byte, then waits for busy
  // to rise and fall again.  uart_tx_data keeps the last byte sent until the
  // next strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            uart_tx_data <= mem[rd_ptr];
            uart_tx_en   <= 1'b1;
            state        <= WAIT_BUSY;
          end else begin
            uart_tx_en   <= 1'b0;
          end
        end
        WAIT_BUSY: begin
          uart_tx_en <= 1'b0;
          if (uart_tx_busy) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          uart_tx_en <= 1'b0;
          if (!uart_tx_busy) begin
            state <= IDLE;
          end
        end
        default: begin
          uart_tx_en <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo.  A behavioural stand-in for uart_tx
// raises busy one cycle after each strobe and holds it for frame_len cycles.
// force_busy lets a test pin busy high.  Accepted bytes go onto a scoreboard
// queue.  A negedge monitor pops the queue on every strobe and checks the byte
// order and the spacing between strobes.

module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] uart_tx_data;
  logic       uart_tx_en;
  logic       uart_tx_busy;
  logic [4:0] count;
  logic       empty;
  logic       full;

  logic       force_busy;
  int         frame_len;
  int         frame_cnt;

  logic [7:0] sb[$];
  int         assertions;
  int         failures;
  int         strobe_count;
  bit         have_prev;
  bit         seen_high;
  bit         seen_low;

  uart_tx_fifo #(.DATA_BITS(8), .DEPTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .uart_tx_data (uart_tx_data),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_busy (uart_tx_busy),
    .count        (count),
    .empty        (empty),
    .full         (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural transmitter: busy starts on the edge after a strobe and lasts frame_len cycles.
  always @(posedge clk) begin
    if (uart_tx_en) frame_cnt <= frame_len;
    else if (frame_cnt != 0) frame_cnt <= frame_cnt - 1;
  end

  assign uart_tx_busy = force_busy || (frame_cnt != 0);

  // Scoreboard monitor: every strobe must carry the oldest outstanding byte.
  // Busy must also have risen and fallen since the previous strobe.
  always @(negedge clk) begin
    if (!rst && uart_tx_en) begin
      strobe_count++;
      assertions++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL strobe_unexpected: got data 0x%02h, expected no strobe", uart_tx_data);
      end else begin
        logic [7:0] exp_b;
        exp_b = sb.pop_front();
        if (uart_tx_data !== exp_b) begin
          failures++;
          $display("[TB] FAIL strobe_data: got 0x%02h, expected 0x%02h", uart_tx_data, exp_b);
        end
      end
      if (have_prev) begin
        assertions++;
        if (!(seen_high && seen_low)) begin
          failures++;
          $display("[TB] FAIL strobe_spacing: busy high/low seen %0d/%0d, expected 1/1", seen_high, seen_low);
        end
      end
      have_prev = 1'b1;
      seen_high = 1'b0;
      seen_low  = 1'b0;
    end else begin
      if (uart_tx_busy) seen_high = 1'b1;
      else if (seen_high) seen_low = 1'b1;
    end
  end

  // Present one byte for one cycle and record it on the scoreboard if it is accepted.
  task automatic push_byte(input logic [7:0] b, output bit accepted);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    accepted = in_ready;
    if (accepted) sb.push_back(b);
  endtask

  task automatic release_input();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait until the FIFO, the scoreboard and the transmitter have all been quiet for a few cycles.
  task automatic wait_idle(input int budget, output bit ok);
    int stable;
    stable = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && empty && !uart_tx_busy && !uart_tx_en) stable++;
      else stable = 0;
      if (stable >= 4) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    assertions++;
    if (count !== 5'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d, expected 0", count); end
    assertions++;
    if (empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty: got %0d, expected 1", empty); end
    assertions++;
    if (full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full: got %0d, expected 0", full); end
    assertions++;
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %0d, expected 1", in_ready); end
    assertions++;
    if (uart_tx_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_en: got %0d, expected 0", uart_tx_en); end
    assertions++;
    if (uart_tx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_data: got 0x%02h, expected 0x00", uart_tx_data); end
  endtask

  task automatic test_single_byte();
    bit acc;
    bit ok;
    push_byte(8'hA5, acc);
    release_input();
    assertions++;
    if (count !== 5'd1 || uart_tx_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_after_push: got count %0d en %0d, expected 1 0", count, uart_tx_en);
    end
    @(negedge clk);
    assertions++;
    if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'hA5 || count !== 5'd0) begin
      failures++;
      $display("[TB] FAIL single_strobe: got en %0d data 0x%02h count %0d, expected 1 0xa5 0", uart_tx_en, uart_tx_data, count);
    end
    @(negedge clk);
    assertions++;
    if (uart_tx_en !== 1'b0) begin failures++; $display("[TB] FAIL single_pulse_width: got en %0d, expected 0", uart_tx_en); end
    wait_idle(200, ok);
    assertions++;
    if (!ok) begin failures++; $display("[TB] FAIL single_timeout: got idle %0d, expected 1", ok); end
    assertions++;
    if (uart_tx_data !== 8'hA5) begin failures++; $display("[TB] FAIL single_data_hold: got 0x%02h, expected 0xa5", uart_tx_data); end
  endtask

  task automatic test_fill();
    bit acc;
    bit ok;
    int sc;
    int n_acc;
    force_busy = 1'b1;
    frame_len = 8;
    sc = strobe_count;
    n_acc = 0;
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i), acc);
      if (acc) n_acc++;
    end
    release_input();
    assertions++;
    if (n_acc != 16) begin failures++; $display("[TB] FAIL fill_accepted: got %0d, expected 16", n_acc); end
    assertions++;
    if (count !== 5'd16 || full !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fill_status: got count %0d full %0d ready %0d, expected 16 1 0", count, full, in_ready);
    end
    push_byte(8'hFF, acc);
    release_input();
    assertions++;
    if (acc !== 1'b0 || count !== 5'd16) begin
      failures++;
      $display("[TB] FAIL fill_overflow: got accepted %0d count %0d, expected 0 16", acc, count);
    end
    force_busy = 1'b0;
    wait_idle(2000, ok);
    assertions++;
    if (!ok || strobe_count - sc != 16) begin
      failures++;
      $display("[TB] FAIL fill_drain: got idle %0d strobes %0d, expected 1 16", ok, strobe_count - sc);
    end
  endtask

  task automatic test_simultaneous();
    bit acc;
    bit ok;
    force_busy = 1'b1;
    push_byte(8'h11, acc);
    release_input();
    @(negedge clk);
    force_busy = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    if (in_ready) sb.push_back(8'h3C);
    @(negedge clk);
    in_valid = 1'b0;
    assertions++;
    if (count !== 5'd1 || uart_tx_en !== 1'b1 || uart_tx_data !== 8'h11) begin
      failures++;
      $display("[TB] FAIL simul_pushpop: got count %0d en %0d data 0x%02h, expected 1 1 0x11", count, uart_tx_en, uart_tx_data);
    end
    wait_idle(500, ok);
    assertions++;
    if (!ok || uart_tx_data !== 8'h3C) begin
      failures++;
      $display("[TB] FAIL simul_second: got idle %0d data 0x%02h, expected 1 0x3c", ok, uart_tx_data);
    end
  endtask

  task automatic test_wrap();
    int sent;
    int guard;
    int sc;
    bit ok;
    frame_len = 4;
    sent = 0;
    guard = 0;
    sc = strobe_count;
    while (sent < 40 && guard < 5000) begin
      @(negedge clk);
      guard++;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'(8'h40 + sent);
      if (in_valid && in_ready) begin
        sb.push_back(in_data);
        sent++;
      end
    end
    release_input();
    wait_idle(2000, ok);
    assertions++;
    if (!ok || sent != 40 || strobe_count - sc != 40) begin
      failures++;
      $display("[TB] FAIL wrap_stream: got idle %0d sent %0d strobes %0d, expected 1 40 40", ok, sent, strobe_count - sc);
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    bit ok;
    int sc;
    int guard;
    force_busy = 1'b1;
    frame_len = 30;
    sc = strobe_count;
    for (int i = 0; i < 5; i++) push_byte(8'(8'h50 + i), acc);
    release_input();
    force_busy = 1'b0;
    guard = 0;
    while (strobe_count == sc && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    assertions++;
    if (strobe_count != sc + 1) begin failures++; $display("[TB] FAIL rstmid_first: got strobes %0d, expected 1", strobe_count - sc); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    assertions++;
    if (count !== 5'd0 || empty !== 1'b1 || uart_tx_en !== 1'b0 || uart_tx_data !== 8'h00) begin
      failures++;
      $display("[TB] FAIL rstmid_state: got count %0d empty %0d en %0d data 0x%02h, expected 0 1 0 0x00", count, empty, uart_tx_en, uart_tx_data);
    end
    sc = strobe_count;
    push_byte(8'h81, acc);
    release_input();
    guard = 0;
    while (uart_tx_busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    assertions++;
    if (strobe_count != sc || uart_tx_busy) begin
      failures++;
      $display("[TB] FAIL rstmid_hold: got strobes %0d busy %0d, expected 0 0", strobe_count - sc, uart_tx_busy);
    end
    wait_idle(500, ok);
    assertions++;
    if (!ok || strobe_count != sc + 1 || uart_tx_data !== 8'h81) begin
      failures++;
      $display("[TB] FAIL rstmid_resume: got idle %0d strobes %0d data 0x%02h, expected 1 1 0x81", ok, strobe_count - sc, uart_tx_data);
    end
  endtask

  task automatic test_stuck_busy();
    bit acc;
    bit ok;
    int sc;
    force_busy = 1'b1;
    frame_len = 6;
    sc = strobe_count;
    for (int i = 0; i < 3; i++) push_byte(8'(8'hC0 + i), acc);
    release_input();
    repeat (1000) @(negedge clk);
    assertions++;
    if (strobe_count != sc || count !== 5'd3 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stuck_busy: got strobes %0d count %0d ready %0d, expected 0 3 1", strobe_count - sc, count, in_ready);
    end
    force_busy = 1'b0;
    wait_idle(500, ok);
    assertions++;
    if (!ok || strobe_count != sc + 3) begin
      failures++;
      $display("[TB] FAIL stuck_release: got idle %0d strobes %0d, expected 1 3", ok, strobe_count - sc);
    end
  endtask

  // Main sequence: every scenario in turn, then the summary line.
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    force_busy = 1'b0;
    frame_len = 10;
    frame_cnt = 0;
    assertions = 0;
    failures = 0;
    strobe_count = 0;
    have_prev = 1'b0;
    seen_high = 1'b0;
    seen_low = 1'b0;
    test_reset();
    test_single_byte();
    test_fill();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    test_stuck_busy();
    assertions++;
    if (sb.size() != 0) begin failures++; $display("[TB] FAIL scoreboard_leftover: got %0d, expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
